// File: rtl/sc_stream_sequencer.sv
// ----------------------------------------------------------------------------
// sc_stream_sequencer
//
// Sequences one stochastic-computing evaluation of the LFSR/comparator/OR
// circuit block. The controller seeds the circuit's LFSR, closes the
// shift-register and delay-chain feedback loops through itself, skips the
// pipeline warm-up and counts ones on the circuit output over STREAM_LEN
// cycles. The count is returned to the host through a start/done handshake.
//
// Phase sequence: IDLE -> LOAD (1) -> WARMUP (DEPTH) -> RUN (STREAM_LEN)
//                 -> DONE (1) -> IDLE
//
// Optional build macro:
//   SC_BIPOLAR_EN  result becomes a signed CNT_W+1 bit bipolar value,
//                  2*count - STREAM_LEN. Undefined: unsigned count of ones.
//
// The rst_n port keeps its historical name but is a synchronous,
// active-HIGH reset. DEPTH and STREAM_LEN must both be at least 1.
// ----------------------------------------------------------------------------
module sc_stream_sequencer #(
    parameter int WIDTH      = 8,
    parameter int STREAM_LEN = 256,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WIDTH-1:0]        seed,
    input  logic [WIDTH-1:0]        operand,
    output logic                    busy,
    output logic                    done,
`ifdef SC_BIPOLAR_EN
    output logic signed [CNT_W:0]   result,
`else
    output logic [CNT_W-1:0]        result,
`endif
    output logic                    circ_hold,
    output logic [WIDTH-1:0]        circ_s,
    input  logic [WIDTH-1:0]        circ_s_fb,
    output logic [WIDTH-1:0]        circ_b,
    output logic [DEPTH-1:0]        circ_x,
    input  logic [DEPTH-1:0]        circ_x_fb,
    input  logic                    circ_bit
);

    // The phase counter only ever has to reach the longer of the two
    // timed phases minus one.
    localparam int MAX_CYC = (STREAM_LEN > DEPTH) ? STREAM_LEN : DEPTH;
    localparam int CYC_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   seed_q;     // latched LFSR seed (never zero)
    logic [WIDTH-1:0]   operand_q;  // latched comparator threshold
    logic [CYC_W-1:0]   cyc_cnt;    // cycle index within WARMUP or RUN
    logic [CNT_W-1:0]   acc;        // ones counted so far in RUN
    logic [CNT_W-1:0]   count_next; // acc including the current sample

    logic               warm_last;
    logic               run_last;
    logic               timed_phase;

    assign warm_last   = (cyc_cnt == CYC_W'(DEPTH - 1));
    assign run_last    = (cyc_cnt == CYC_W'(STREAM_LEN - 1));
    assign timed_phase = (state == S_WARMUP) || (state == S_RUN);
    assign count_next  = acc + CNT_W'(circ_bit);

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: abort cancels any busy phase, start only in IDLE.
    always_comb begin
        // NOTE: default assignment first, so no path through the case can
        // leave state_nxt unassigned and infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = abort ? S_IDLE : S_WARMUP;
            end
            S_WARMUP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (warm_last) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (run_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch: seed and threshold captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            seed_q    <= '0;
            operand_q <= '0;
        end else if (state == S_IDLE && start) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            seed_q    <= (seed == '0) ? WIDTH'(1) : seed;
            operand_q <= operand;
        end
    end

    // Phase counter and ones accumulator.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cyc_cnt <= '0;
            acc     <= '0;
        end else begin
            // Restart the index on every phase change so WARMUP and RUN
            // both begin counting from zero.
            if (!timed_phase || (state_nxt != state)) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end

            // Warm-up samples are discarded; only RUN accumulates.
            if (state == S_RUN) begin
                acc <= count_next;
            end else begin
                acc <= '0;
            end
        end
    end

    // Result register: loaded with the final count as RUN completes, so it
    // is already valid during the DONE cycle that pulses done.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            result <= '0;
        end else if (state == S_RUN && run_last && !abort) begin
`ifdef SC_BIPOLAR_EN
            // Wraps modulo 2^(CNT_W+1); the true value always fits.
            result <= {count_next, 1'b0} - (CNT_W + 1)'(STREAM_LEN);
`else
            result <= count_next;
`endif
        end
    end

    // Output decode: circuit drive and handshake flags per phase.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        circ_hold = 1'b1;
        circ_s    = '0;
        circ_b    = '0;
        circ_x    = '0;
        case (state)
            S_LOAD: begin
                // Seed the LFSR and flush the delay chain with zeros.
                busy      = 1'b1;
                circ_hold = 1'b0;
                circ_s    = seed_q;
                circ_b    = operand_q;
                circ_x    = '0;
            end
            S_WARMUP, S_RUN: begin
                // Close the circuit's feedback loops through the controller.
                busy      = 1'b1;
                circ_hold = 1'b0;
                circ_s    = circ_s_fb;
                circ_b    = operand_q;
                circ_x    = circ_x_fb;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
